e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multiply/divide unit in the Execute stage of the pipelined MIPS core.
- Consumes the same register and extended-immediate-path operands as the ALU.
- Runs mult/multu/div/divu as multi-cycle operations and holds the results in private HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo, and drives Busy to the hazard unit so it can stall later MDU instructions.

Parameters:
- MUL_CYCLES, 5, cycles Busy stays high for mult/multu/madd/maddu.
- DIV_CYCLES, 10, cycles Busy stays high for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- MDUOp  input  4  operation code, encodings in mdu_pkg.
- Start  input  1  one-cycle pulse from E-stage control; starts a mult/div-class op.
- Req  input  1  exception/interrupt request from CP0; blocks the E-stage op this cycle.
- A  input  32  operand rs (forwarded).
- B  input  32  operand rt (forwarded).
- Busy  output  1  multi-cycle op in flight.
- Out  output  32  mfhi/mflo read data.

Behaviour:
- Reset (async, active-high): HI=0, LO=0, Busy=0, counter=0, pending result=0.
- Out is combinational:
  - MDUOp=MFHI gives HI; MDUOp=MFLO gives LO; otherwise 0.
  - Out reflects HI/LO as already committed; no bypass of in-flight results.
- Start accepted when Start=1, Req=0, Busy=0 and MDUOp is MULT/MULTU/DIV/DIVU (or MADD/MADDU with the option).
- On accept:
  - A and B are latched and the result is computed into pending {hi,lo}.
  - Counter loads MUL_CYCLES or DIV_CYCLES.
  - Busy=1 from the next cycle.
- Each busy cycle the counter decrements. When the counter reaches 1, the next edge commits pending to HI/LO and clears Busy.
- Net timing: Busy is high exactly N cycles after the Start cycle. The hazard unit stalls on (Start|Busy).
- MTHI/MTLO: write A to HI/LO at the edge when Req=0 and Busy=0; zero latency.
- Arithmetic:
  - mult: signed 32x32 to 64, {HI,LO}.
  - multu: unsigned 32x32 to 64.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: op still takes DIV_CYCLES and Busy behaves normally; HI and LO retain their old values.
- Start or MTHI/MTLO while Busy=1: ignored (illegal by hazard-unit contract; the MDU must not corrupt state).
- Req while Busy=1: the in-flight op is from an older instruction, so it continues and commits normally. Req only suppresses acceptance in its own cycle.
- Start with a non-start MDUOp: ignored.
- Reset mid-operation: the op is aborted, all state returns to reset values, and nothing is committed.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MDUOp MADD/MADDU accepted with MUL_CYCLES latency. Commit {HI,LO} = {HI,LO} + product (signed/unsigned), mod 2^64. HI/LO are sampled at accept time.
- Undefined: MADD/MADDU encodings are treated as NONE (Start ignored, no state change).

Decomposition:
- mdu_pkg holds:
  - MDUOp encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10.
  - Default MUL_CYCLES and DIV_CYCLES constants.
- One sub-module, mdu_calc: combinational 64-bit result from op, A, B, HI, LO. This includes the divide-by-zero keep-old rule.
- e_mdu keeps the counter, Busy, HI/LO and the read mux.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE, B=3 with Start: Busy high for 5 cycles then low. MFHI gives 0xFFFFFFFF; MFLO gives 0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=2: HI=1, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2: Busy high for 10 cycles. LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI A=0x1234 then DIVU B=0: Busy high for 10 cycles, HI stays 0x1234.
- Start MULT with Req=1: Busy stays 0 and HI/LO are unchanged. Then Req pulses during an accepted DIVU 7/2: result still commits, LO=3, HI=1.
- Assert reset at cycle 3 of a DIV: Busy=0 immediately and HI=LO=0 afterwards.
- With MDU_MADD_EN: HI:LO=0:5, MADD A=2, B=3 gives LO=11.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the Execute-stage multiply/divide unit:
//               MDUOp encodings, default latencies and op-class helpers.
//               Optional feature macro: MDU_MADD_EN (enables MADD/MADDU).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10
  } mdu_op_e;

  localparam int c_MUL_CYCLES = 5;
  localparam int c_DIV_CYCLES = 10;
  localparam int c_CNT_W      = 8;

  // True for op codes that launch a multi-cycle operation on Start.
  function automatic logic mdu_is_start(input logic [3:0] op);
    logic v;
    v = 1'b0;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: v = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    v = 1'b1;
`endif
      default:                                v = 1'b0;
    endcase
    return v;
  endfunction

  // True for the divide class, which uses the longer latency.
  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : mdu_calc
// Description : Combinational 64-bit {hi,lo} result for mult/multu/div/divu
//               (and madd/maddu when MDU_MADD_EN is defined). Divide by zero
//               returns the current {hi,lo} so the commit leaves them intact.
// Revision    : 1.0 - initial release
// ============================================================================
import mdu_pkg::*;

module mdu_calc (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] w_as, w_bs, w_au, w_bu;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_mag_a, w_mag_b, w_div_a, w_div_b;
  logic [31:0] w_q, w_r, w_q_s, w_r_s;
  logic        w_bzero;

  // Products are taken modulo 2^64 on sign/zero-extended operands.
  assign w_as     = {{32{a[31]}}, a};
  assign w_bs     = {{32{b[31]}}, b};
  assign w_au     = {32'd0, a};
  assign w_bu     = {32'd0, b};
  assign w_prod_s = w_as * w_bs;
  assign w_prod_u = w_au * w_bu;

  // Signed divide runs on magnitudes; 0x80000000 keeps its bit pattern as an
  // unsigned magnitude, which makes INT_MIN / -1 fall out as 0x80000000 rem 0.
  assign w_mag_a  = a[31] ? (~a + 32'd1) : a;
  assign w_mag_b  = b[31] ? (~b + 32'd1) : b;
  assign w_div_a  = (op == MDU_DIV) ? w_mag_a : a;
  assign w_div_b  = (op == MDU_DIV) ? w_mag_b : b;
  assign w_bzero  = (b == 32'd0);
  assign w_q      = w_bzero ? 32'd0 : (w_div_a / w_div_b);
  assign w_r      = w_bzero ? 32'd0 : (w_div_a % w_div_b);
  assign w_q_s    = (a[31] ^ b[31]) ? (~w_q + 32'd1) : w_q;
  assign w_r_s    = a[31] ? (~w_r + 32'd1) : w_r;

  // Select the result for the requested op; anything else keeps {hi,lo}.
  always_comb begin
    res = {hi, lo};
    case (op)
      MDU_MULT:  res = w_prod_s;
      MDU_MULTU: res = w_prod_u;
      MDU_DIV:   if (!w_bzero) res = {w_r_s, w_q_s};
      MDU_DIVU:  if (!w_bzero) res = {w_r, w_q};
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi, lo} + w_prod_s;
      MDU_MADDU: res = {hi, lo} + w_prod_u;
`endif
      default:   res = {hi, lo};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
// Module      : e_mdu
// Description : Execute-stage multiply/divide unit. Holds HI/LO, runs
//               multi-cycle mult/div ops with a down-counter and Busy flag,
//               and serves mfhi/mflo/mthi/mtlo.
//               Optional feature macro: MDU_MADD_EN (enables MADD/MADDU).
// Revision    : 1.0 - initial release
// ============================================================================
import mdu_pkg::*;

module e_mdu #(
  parameter int MUL_CYCLES = c_MUL_CYCLES,
  parameter int DIV_CYCLES = c_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out
);

  localparam logic [c_CNT_W-1:0] c_MUL_LD = c_CNT_W'(MUL_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LD = c_CNT_W'(DIV_CYCLES);

  logic [31:0]        r_hi, r_lo;
  logic [63:0]        r_pend;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;
  logic [63:0]        w_calc;
  logic               w_accept;
  logic               w_mt_ok;

  // Result is computed at accept time from the live operands and HI/LO.
  mdu_calc u_calc (
    .op  (MDUOp),
    .a   (A),
    .b   (B),
    .hi  (r_hi),
    .lo  (r_lo),
    .res (w_calc)
  );

  // Req only blocks the instruction in its own cycle; an in-flight op keeps going.
  assign w_accept = Start & ~Req & ~r_busy & mdu_is_start(MDUOp);
  assign w_mt_ok  = ~Req & ~r_busy;

  // Sequencer: latch pending result, count down, commit to HI/LO at the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_pend <= 64'd0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (w_accept) begin
      r_pend <= w_calc;
      r_cnt  <= mdu_is_div(MDUOp) ? c_DIV_LD : c_MUL_LD;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == c_CNT_W'(1)) begin
        r_hi   <= r_pend[63:32];
        r_lo   <= r_pend[31:0];
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt  <= r_cnt - c_CNT_W'(1);
      end
    end else if (w_mt_ok) begin
      if (MDUOp == MDU_MTHI) r_hi <= A;
      if (MDUOp == MDU_MTLO) r_lo <= A;
    end
  end

  assign Busy = r_busy;

  // Read mux shows committed HI/LO only.
  always_comb begin
    Out = 32'd0;
    case (MDUOp)
      MDU_MFHI: Out = r_hi;
      MDU_MFLO: Out = r_lo;
      default:  Out = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
